uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, next generation of the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits, glitch reject,
// one-entry holding register with valid/ready handshake and sticky overrun.
module uart_rx_cfg #(
    parameter int DELAY_FRAMES = 234,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CW = $clog2(DELAY_FRAMES + 1);
    localparam logic [CW-1:0] FULL = CW'(DELAY_FRAMES);
    localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t state, state_n;

    logic                 sync1, rxs;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           bitn, bitn_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 armed, armed_n;
    logic                 ferr_fin;
    logic                 done;
    logic                 valid_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 pe_n, fe_n, ovr_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + ONE;
        bitn_n   = bitn;
        shift_n  = shift;
        perr_n   = perr;
        ferr_n   = ferr;
        armed_n  = armed | rxs;
        ferr_fin = ferr | ~rxs;
        done     = 1'b0;
        valid_n  = rx_valid & ~rx_ready;
        data_n   = rx_data;
        pe_n     = rx_parity_err;
        fe_n     = rx_frame_err;
        ovr_n    = rx_overrun;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (armed && !rxs) begin
                    state_n = START;
                    cnt_n   = ONE;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = ONE;
                        bitn_n  = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n   = ONE;
                    shift_n = {rxs, shift[DATA_BITS-1:1]};
                    bitn_n  = bitn + 4'd1;
                    if (bitn == LAST_DATA) begin
                        bitn_n  = '0;
                        state_n = (PARITY != 0) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (cnt == FULL) begin
                    cnt_n   = ONE;
                    // odd: data^parity must be 1; even: must be 0
                    perr_n  = (^shift) ^ rxs ^ (PARITY == 1);
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL) begin
                    cnt_n  = ONE;
                    ferr_n = ferr_fin;
                    bitn_n = bitn + 4'd1;
                    if (bitn == LAST_STOP) begin
                        bitn_n  = '0;
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Re-arming needs the line seen high again, so a held break reports once
        if (done) begin
            armed_n = 1'b0;
            if (!rx_valid || rx_ready) begin
                valid_n = 1'b1;
                data_n  = shift_n;
                pe_n    = (PARITY != 0) && perr;
                fe_n    = ferr_fin;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b1;
            rxs           <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bitn          <= '0;
            shift         <= '0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            armed         <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            sync1         <= uart_rx;
            rxs           <= sync1;
            state         <= state_n;
            cnt           <= cnt_n;
            bitn          <= bitn_n;
            shift         <= shift_n;
            perr          <= perr_n;
            ferr          <= ferr_n;
            armed         <= armed_n;
            rx_valid      <= valid_n;
            rx_data       <= data_n;
            rx_parity_err <= pe_n;
            rx_frame_err  <= fe_n;
            rx_overrun    <= ovr_n;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) driven with
// random frames and compared against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic       a_valid, a_pe, a_fe, a_ovr, a_busy;
    logic [7:0] a_data;
    logic       b_valid, b_pe, b_fe, b_ovr, b_busy;
    logic [6:0] b_data;
    logic       c_valid, c_pe, c_fe, c_ovr, c_busy;
    logic [7:0] c_data;

    uart_rx_cfg #(.DELAY_FRAMES(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .uart_rx(line_a), .rx_ready(ready_a),
        .rx_valid(a_valid), .rx_data(a_data), .rx_parity_err(a_pe),
        .rx_frame_err(a_fe), .rx_overrun(a_ovr), .rx_busy(a_busy)
    );

    uart_rx_cfg #(.DELAY_FRAMES(D), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .uart_rx(line_b), .rx_ready(ready_b),
        .rx_valid(b_valid), .rx_data(b_data), .rx_parity_err(b_pe),
        .rx_frame_err(b_fe), .rx_overrun(b_ovr), .rx_busy(b_busy)
    );

    uart_rx_cfg #(.DELAY_FRAMES(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .uart_rx(line_c), .rx_ready(ready_c),
        .rx_valid(c_valid), .rx_data(c_data), .rx_parity_err(c_pe),
        .rx_frame_err(c_fe), .rx_overrun(c_ovr), .rx_busy(c_busy)
    );

    // Accepted frames packed as {ferr, perr, data[8:0]}
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    logic [10:0] qc[$];

    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (a_valid && ready_a) qa.push_back({a_fe, a_pe, 1'b0, a_data});
        if (b_valid && ready_b) qb.push_back({b_fe, b_pe, 2'b00, b_data});
        if (c_valid && ready_c) qc.push_back({c_fe, c_pe, 1'b0, c_data});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int d, input logic v);
        case (d)
            0: line_a = v;
            1: line_b = v;
            default: line_c = v;
        endcase
    endtask

    // bits[0] goes on the line first; each bit lasts D clocks
    task automatic send(input int d, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(d, bits[i]);
            tick(D);
        end
        set_line(d, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        logic [10:0] got;
        do_reset();
        got = {a_valid, a_pe, a_fe, a_ovr, a_busy, 1'b0, a_data[4:0]};
        n_checks++;
        if ({a_valid, a_pe, a_fe, a_ovr, a_busy, a_data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h required 0", got);
        end
        n_checks++;
        if ({b_valid, b_pe, b_fe, b_ovr, b_busy, b_data} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h required 0",
                     {b_valid, b_pe, b_fe, b_ovr, b_busy, b_data});
        end
        n_checks++;
        if ({c_valid, c_pe, c_fe, c_ovr, c_busy, c_data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_c: got %h required 0",
                     {c_valid, c_pe, c_fe, c_ovr, c_busy, c_data});
        end
    endtask

    task automatic test_8n1_random();
        logic [7:0]  v;
        logic [10:0] exp, got;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            exp = {2'b00, 1'b0, v};
            send(0, {6'h3f, 1'b1, v, 1'b0}, 10);
            tick(4);
            n_checks++;
            if (qa.size() != 1) begin
                n_fail++;
                $display("FAIL 8n1_count[%0d]: got %0d required 1", i, qa.size());
            end
            if (qa.size() > 0) begin
                got = qa.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL 8n1_frame[%0d]: got %h required %h", i, got, exp);
                end
            end
            qa.delete();
        end
    endtask

    task automatic test_parity_even();
        logic [6:0]  v;
        logic        pbit, bad;
        logic [10:0] exp, got;
        for (int i = 0; i < 10; i++) begin
            v = (i < 2) ? 7'h41 : 7'($urandom_range(0, 127));
            bad = (i < 2) ? 1'(i) : 1'($urandom_range(0, 1));
            // even parity: ones in data plus parity bit must be even
            pbit = 1'(($countones(v) + (bad ? 1 : 0)) % 2);
            exp = {1'b0, 1'(($countones(v) + pbit) % 2 != 0), 2'b00, v};
            send(1, {6'h3f, 1'b1, pbit, v, 1'b0}, 10);
            tick(4);
            n_checks++;
            if (qb.size() != 1) begin
                n_fail++;
                $display("FAIL parity_count[%0d]: got %0d required 1", i, qb.size());
            end
            if (qb.size() > 0) begin
                got = qb.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL parity_frame[%0d]: got %h required %h", i, got, exp);
                end
            end
            qb.delete();
        end
    endtask

    task automatic test_stop2();
        logic [7:0]  v;
        logic        s1, s2;
        logic [10:0] exp, got;
        for (int i = 0; i < 8; i++) begin
            v  = 8'($urandom_range(0, 255));
            s1 = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            s2 = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            exp = {!(s1 && s2), 1'b0, 1'b0, v};
            send(2, {5'h1f, s2, s1, v, 1'b0}, 11);
            tick(D);
            n_checks++;
            if (qc.size() != 1) begin
                n_fail++;
                $display("FAIL stop2_count[%0d]: got %0d required 1", i, qc.size());
            end
            if (qc.size() > 0) begin
                got = qc.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL stop2_frame[%0d]: got %h required %h", i, got, exp);
                end
            end
            qc.delete();
        end
    endtask

    task automatic test_glitch();
        logic seen_busy, seen_valid;
        seen_busy  = 1'b0;
        seen_valid = 1'b0;
        line_a = 1'b0;
        tick(4);
        line_a = 1'b1;
        repeat (40) @(negedge clk) begin
            if (a_busy) seen_busy = 1'b1;
            if (a_valid) seen_valid = 1'b1;
        end
        tick(1);
        n_checks++;
        if (seen_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b required 1", seen_busy);
        end
        n_checks++;
        if (seen_valid !== 1'b0 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_valid: got %b/%0d required 0/0", seen_valid, qa.size());
        end
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got %b required 0", a_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  v[4];
        logic [10:0] got;
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom_range(0, 255));
            send(0, {6'h3f, 1'b1, v[i], 1'b0}, 10);
        end
        tick(4);
        n_checks++;
        if (qa.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required 4", qa.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (qa.size() > 0) begin
                got = qa.pop_front();
                n_checks++;
                if (got !== {3'b000, v[i]}) begin
                    n_fail++;
                    $display("FAIL b2b_frame[%0d]: got %h required %h", i, got, {3'b000, v[i]});
                end
            end
        end
        qa.delete();
    endtask

    task automatic test_break();
        logic [7:0]  v;
        logic [10:0] got;
        line_a = 1'b0;
        tick(D * 25);
        n_checks++;
        if (qa.size() != 1) begin
            n_fail++;
            $display("FAIL break_count: got %0d required 1", qa.size());
        end
        if (qa.size() > 0) begin
            got = qa.pop_front();
            n_checks++;
            if (got !== 11'h400) begin
                n_fail++;
                $display("FAIL break_frame: got %h required 400", got);
            end
        end
        qa.delete();
        line_a = 1'b1;
        tick(D);
        v = 8'($urandom_range(0, 255));
        send(0, {6'h3f, 1'b1, v, 1'b0}, 10);
        tick(4);
        n_checks++;
        if (qa.size() != 1 || qa[0] !== {3'b000, v}) begin
            n_fail++;
            $display("FAIL break_rearm: got %0d frames required 1 of %h", qa.size(), v);
        end
        qa.delete();
    endtask

    task automatic test_overrun();
        ready_a = 1'b0;
        send(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
        tick(20);
        n_checks++;
        if ({a_valid, a_data, a_ovr} !== {1'b1, 8'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%b d=%h o=%b required v=1 d=11 o=1",
                     a_valid, a_data, a_ovr);
        end
        ready_a = 1'b1;
        tick(2);
        n_checks++;
        if (a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drop: got %b required 0", a_valid);
        end
        tick(200);
        n_checks++;
        if (qa.size() != 1 || qa[0] !== 11'h011 || a_ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_lost: got %0d frames ovr=%b required 1 frame 11 ovr=1",
                     qa.size(), a_ovr);
        end
        qa.delete();
    endtask

    task automatic test_reset_mid_frame();
        set_line(0, 1'b0);
        tick(D);
        set_line(0, 1'b1);
        tick(D);
        set_line(0, 1'b0);
        tick(D);
        set_line(0, 1'b1);
        tick(D);
        set_line(0, 1'b0);
        tick(D / 2);
        rst = 1'b1;
        tick(3);
        n_checks++;
        if ({a_busy, a_valid, a_ovr} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_state: got %b required 000", {a_busy, a_valid, a_ovr});
        end
        rst = 1'b0;
        line_a = 1'b1;
        tick(20);
        qa.delete();
        send(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
        tick(4);
        n_checks++;
        if (qa.size() != 1 || qa[0] !== 11'h05A) begin
            n_fail++;
            $display("FAIL midrst_frame: got %0d frames required one 05a", qa.size());
        end
    endtask

    initial begin
        test_reset();
        test_8n1_random();
        test_parity_even();
        test_stop2();
        test_glitch();
        test_back_to_back();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
